// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: captures rising edges on the PE spike lines, serialises
// them round-robin into a small event FIFO, and presents them as AER words
// {pe index, timestep}. Also owns the timestep counter and the drain handshake
// with the sequencer.
module spike_aer_encoder #(
  parameter int NUM_PE     = 8,
  parameter int TS_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_PE-1:0]         spike_in,
  input  logic                      step_end,
  input  logic                      aer_ready,
  output logic                      aer_valid,
  output logic [$clog2(NUM_PE)-1:0] aer_addr,
  output logic [TS_WIDTH-1:0]       aer_ts,
  output logic                      step_ready,
  output logic                      overflow,
  output logic                      step_err
);

  localparam int AW = $clog2(NUM_PE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = AW + TS_WIDTH;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state, state_next;
  logic [NUM_PE-1:0]   spike_q;
  logic [NUM_PE-1:0]   pend, pend_next;
  logic [NUM_PE-1:0]   edge_vec;
  logic [NUM_PE-1:0]   gnt_vec;
  logic [AW-1:0]       ptr, ptr_next;
  logic [AW-1:0]       winner;
  logic                grant;
  logic                drop;
  logic [TS_WIDTH-1:0] ts;
  logic                ts_inc;
  logic                err_set;

  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                fifo_full;
  logic                push, pop;
  logic [DW-1:0]       head;

  assign edge_vec  = spike_in & ~spike_q;
  assign fifo_full = (count == CW'(FIFO_DEPTH));
  assign push      = grant;
  assign pop       = aer_valid & aer_ready;

  // Round-robin arbiter: lowest pending index at or above ptr, wrapping.
  always_comb begin
    logic [2*NUM_PE-1:0] pend_dbl;
    logic [NUM_PE-1:0]   pend_rot;
    logic [AW-1:0]       offset;
    logic [AW:0]         sum;
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    grant    = 1'b0;
    winner   = '0;
    offset   = '0;
    pend_dbl = {pend, pend} >> ptr;
    pend_rot = pend_dbl[NUM_PE-1:0];
    // Scanning downwards leaves the smallest set offset as the final winner.
    for (int j = NUM_PE - 1; j >= 0; j--) begin
      if (pend_rot[j]) offset = AW'(j);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (AW + 1)'(NUM_PE)) sum = sum - (AW + 1)'(NUM_PE);
    // Full is the pre-pop occupancy: no grant while full even if popping.
    if ((|pend) && !fifo_full) begin
      grant  = 1'b1;
      winner = sum[AW-1:0];
    end
  end

  // Pending-bit update: a same-cycle edge on the granted bit keeps it pending.
  always_comb begin
    gnt_vec   = grant ? (NUM_PE'(1) << winner) : '0;
    pend_next = (pend & ~gnt_vec) | edge_vec;
    drop      = |(edge_vec & pend & ~gnt_vec);
    ptr_next  = (winner == AW'(NUM_PE - 1)) ? '0 : winner + 1'b1;
  end

  // Edge-capture, pending, arbiter pointer and overflow registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spike_q  <= '0;
      pend     <= '0;
      ptr      <= '0;
      overflow <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      spike_q <= spike_in;
      pend    <= pend_next;
      if (grant) ptr <= ptr_next;
      if (drop) overflow <= 1'b1;
    end
  end

  // Timestep FSM next-state logic.
  always_comb begin
    state_next = state;
    ts_inc     = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (step_end) begin
          if (|pend) state_next = DRAIN;
          else       ts_inc     = 1'b1;
        end
      end
      DRAIN: begin
        if (step_end) err_set = 1'b1;
        if (pend_next == '0) begin
          ts_inc     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Timestep FSM state, timestep counter and step_err flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ts       <= '0;
      step_err <= 1'b0;
    end else begin
      state <= state_next;
      if (ts_inc)  ts       <= ts + 1'b1;
      if (err_set) step_err <= 1'b1;
    end
  end

  assign step_ready = (state == IDLE);

  // Event FIFO storage.
  // NOTE: the storage array has no reset; emptiness is tracked by the reset
  // pointers and count, so clearing the entries would only cost logic.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {winner, ts};
  end

  // Event FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign aer_valid = (count != '0);
  assign aer_addr  = aer_valid ? head[DW-1:TS_WIDTH] : '0;
  assign aer_ts    = aer_valid ? head[TS_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Testbench for spike_aer_encoder: directed table, hand-written corner-case
// sequences and randomized stimulus, all checked against an event-level model.
module tb_spike_aer_encoder;

  localparam int N     = 8;
  localparam int TSW   = 8;
  localparam int DEPTH = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   spike_in;
  logic           step_end;
  logic           aer_ready;
  logic           aer_valid;
  logic [2:0]     aer_addr;
  logic [TSW-1:0] aer_ts;
  logic           step_ready;
  logic           overflow;
  logic           step_err;

  int n_checks = 0;
  int n_fail   = 0;

  spike_aer_encoder #(.NUM_PE(N), .TS_WIDTH(TSW), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .spike_in   (spike_in),
    .step_end   (step_end),
    .aer_ready  (aer_ready),
    .aer_valid  (aer_valid),
    .aer_addr   (aer_addr),
    .aer_ts     (aer_ts),
    .step_ready (step_ready),
    .overflow   (overflow),
    .step_err   (step_err)
  );

  always #5 clock = ~clock;

  // ---------------- reference model (event level) ----------------
  typedef struct {int addr; int ts;} ev_t;
  ev_t m_q[$];
  bit  m_prev[N];
  bit  m_pend[N];
  int  m_ptr, m_ts;
  bit  m_drain, m_ovf, m_err;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0;
      m_pend[i] = 1'b0;
    end
    m_ptr = 0; m_ts = 0;
    m_drain = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
  endfunction

  function automatic void model_step(logic [N-1:0] sp, bit se, bit rdy);
    bit g = 1'b0;
    int w = -1;
    bit any_old = 1'b0;
    bit any_new = 1'b0;
    for (int i = 0; i < N; i++) if (m_pend[i]) any_old = 1'b1;
    if (any_old && m_q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        if (!g && m_pend[(m_ptr + k) % N]) begin
          g = 1'b1;
          w = (m_ptr + k) % N;
        end
      end
    end
    if (rdy && m_q.size() > 0) void'(m_q.pop_front());
    if (g) begin
      m_q.push_back('{w, m_ts});
      m_ptr = (w + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      bit e  = sp[i] && !m_prev[i];
      bit gi = g && (w == i);
      if (e && m_pend[i] && !gi) m_ovf = 1'b1;
      m_pend[i] = (m_pend[i] && !gi) || e;
      m_prev[i] = sp[i];
      if (m_pend[i]) any_new = 1'b1;
    end
    if (!m_drain) begin
      if (se) begin
        if (any_old) m_drain = 1'b1;
        else         m_ts = (m_ts + 1) % (1 << TSW);
      end
    end else begin
      if (se) m_err = 1'b1;
      if (!any_new) begin
        m_ts = (m_ts + 1) % (1 << TSW);
        m_drain = 1'b0;
      end
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit ne = (m_q.size() > 0);
    check("model_valid",      aer_valid,  ne);
    check("model_addr",       aer_addr,   ne ? m_q[0].addr : 0);
    check("model_ts",         aer_ts,     ne ? m_q[0].ts   : 0);
    check("model_step_ready", step_ready, !m_drain);
    check("model_overflow",   overflow,   m_ovf);
    check("model_step_err",   step_err,   m_err);
  endtask

  // Drive one cycle of inputs, let the edge happen, compare with the model.
  task automatic tick(input logic [N-1:0] sp, input bit se, input bit rdy);
    spike_in  = sp;
    step_end  = se;
    aer_ready = rdy;
    @(posedge clock);
    model_step(sp, se, rdy);
    #1;
    compare_model();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    spike_in  = '0;
    step_end  = 1'b0;
    aer_ready = 1'b0;
    #1;
    model_reset();
    check("rst_valid",      aer_valid,  0);
    check("rst_addr",       aer_addr,   0);
    check("rst_ts",         aer_ts,     0);
    check("rst_step_ready", step_ready, 1);
    check("rst_overflow",   overflow,   0);
    check("rst_step_err",   step_err,   0);
    #3;
    reset_n = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0]   spike;
    bit             se;
    bit             rdy;
    bit             exp_valid;
    logic [2:0]     exp_addr;
    logic [TSW-1:0] exp_ts;
    bit             exp_step_ready;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [N-1:0] sp;
    int pe1_count;

    // Single spike on PE 3, then all PEs from ptr=4, then a timestep bump.
    tbl[0]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[1]  = '{8'h08, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[2]  = '{8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'd0, 1'b1};
    tbl[3]  = '{8'h08, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[5]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[6]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd4, 8'd0, 1'b1};
    tbl[7]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd5, 8'd0, 1'b1};
    tbl[8]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd6, 8'd0, 1'b1};
    tbl[9]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd7, 8'd0, 1'b1};
    tbl[10] = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 1'b1};
    tbl[11] = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd1, 8'd0, 1'b1};
    tbl[12] = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'd0, 1'b1};
    tbl[13] = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd3, 8'd0, 1'b1};
    tbl[14] = '{8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[15] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[16] = '{8'h20, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};
    tbl[17] = '{8'h20, 1'b0, 1'b1, 1'b1, 3'd5, 8'd1, 1'b1};
    tbl[18] = '{8'h20, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1};

    reset_n   = 1'b0;
    spike_in  = '0;
    step_end  = 1'b0;
    aer_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].spike, tbl[i].se, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), aer_valid, tbl[i].exp_valid);
      check($sformatf("tbl%0d_addr", i),  aer_addr,  tbl[i].exp_addr);
      check($sformatf("tbl%0d_ts", i),    aer_ts,    tbl[i].exp_ts);
      check($sformatf("tbl%0d_sr", i),    step_ready, tbl[i].exp_step_ready);
    end

    // Round-robin from ptr=0, then bits 2 and 5 rising together.
    do_reset();
    tick(8'hFF, 1'b0, 1'b1);
    check("rr_first_valid", aer_valid, 0);
    for (int i = 0; i < N; i++) begin
      tick(8'hFF, 1'b0, 1'b1);
      check($sformatf("rr_valid%0d", i), aer_valid, 1);
      check($sformatf("rr_addr%0d", i),  aer_addr,  i);
    end
    tick(8'hFF, 1'b0, 1'b1);
    check("rr_empty", aer_valid, 0);
    tick(8'hDB, 1'b0, 1'b1);
    tick(8'hFF, 1'b0, 1'b1);
    tick(8'hFF, 1'b0, 1'b1);
    check("rr25_first", aer_addr, 2);
    tick(8'hFF, 1'b0, 1'b1);
    check("rr25_second", aer_addr, 5);

    // Backpressure: FIFO fills with 0..3, then drains 0..7 in order.
    do_reset();
    for (int i = 0; i < 8; i++) tick(8'hFF, 1'b0, 1'b0);
    check("bp_valid_held", aer_valid, 1);
    check("bp_head", aer_addr, 0);
    for (int j = 1; j <= 8; j++) begin
      tick(8'hFF, 1'b0, 1'b1);
      if (j <= 7) check($sformatf("bp_addr%0d", j), aer_addr, j);
      else        check("bp_drained", aer_valid, 0);
    end
    check("bp_no_overflow", overflow, 0);

    // Overflow: FIFO full, PE 1 pending, PE 1 re-spikes and is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) tick(8'h3D, 1'b0, 1'b0);
    tick(8'h3F, 1'b0, 1'b0);
    tick(8'h3D, 1'b0, 1'b0);
    check("ovf_before", overflow, 0);
    tick(8'h3F, 1'b0, 1'b0);
    check("ovf_set", overflow, 1);
    pe1_count = 0;
    for (int i = 0; i < 12; i++) begin
      if (aer_valid && aer_addr == 3'd1) pe1_count++;
      tick(8'h3F, 1'b0, 1'b1);
    end
    check("ovf_pe1_once", pe1_count, 1);
    check("ovf_sticky", overflow, 1);

    // Timestep drain with a second step_end during the drain.
    do_reset();
    tick(8'h0F, 1'b0, 1'b0);
    tick(8'h0F, 1'b1, 1'b0);
    check("drain_sr0", step_ready, 0);
    tick(8'h0F, 1'b1, 1'b0);
    check("drain_err", step_err, 1);
    check("drain_sr1", step_ready, 0);
    tick(8'h0F, 1'b0, 1'b0);
    check("drain_sr2", step_ready, 0);
    tick(8'h0F, 1'b0, 1'b0);
    check("drain_done", step_ready, 1);
    check("drain_ts_head", aer_ts, 0);
    tick(8'h0F, 1'b0, 1'b1);
    tick(8'h0F, 1'b0, 1'b1);
    tick(8'h0F, 1'b0, 1'b1);
    check("drain_ts_tail", aer_ts, 0);
    tick(8'h1F, 1'b0, 1'b1);
    tick(8'h1F, 1'b0, 1'b1);
    check("drain_new_addr", aer_addr, 4);
    check("drain_new_ts", aer_ts, 1);

    // Async reset while FIFO non-empty and draining.
    do_reset();
    tick(8'h03, 1'b0, 1'b0);
    tick(8'h03, 1'b1, 1'b0);
    check("pre_rst_valid", aer_valid, 1);
    check("pre_rst_sr", step_ready, 0);
    do_reset();

    // Timestep wrap through all 2^TSW values.
    for (int i = 0; i < 255; i++) tick(8'h00, 1'b1, 1'b1);
    tick(8'h01, 1'b0, 1'b1);
    tick(8'h01, 1'b0, 1'b1);
    check("wrap_ts_max", aer_ts, 255);
    tick(8'h00, 1'b1, 1'b1);
    tick(8'h01, 1'b0, 1'b1);
    tick(8'h01, 1'b0, 1'b1);
    check("wrap_ts_zero", aer_ts, 0);
    check("wrap_valid", aer_valid, 1);

    // Randomized stimulus against the model.
    do_reset();
    sp = '0;
    for (int i = 0; i < 3000; i++) begin
      sp = sp ^ N'($urandom & $urandom & $urandom);
      tick(sp, ($urandom_range(0, 9) == 0),
           (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream consumer of the `pe` array. Samples each PE's `spike` line and captures rising edges as pending events. Serialises pending events through a round-robin arbiter into a small FIFO, and presents them as address-event (AER) words `{pe index, timestep}` on a valid/ready output. Also owns the timestep counter and tells the sequencer when a timestep's spikes have fully drained.

## Interface
Parameters:
- NUM_PE, 8, number of PE spike lines (≥2)
- TS_WIDTH, 8, timestep counter width
- FIFO_DEPTH, 4, event FIFO entries (power of 2, ≥2)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- spike_in  in  NUM_PE  spike outputs of the PE array, one bit per PE
- step_end  in  1  one-cycle pulse from sequencer: current timestep ends
- aer_ready  in  1  downstream accepts the head event
- aer_valid  out  1  FIFO non-empty; head event presented
- aer_addr  out  $clog2(NUM_PE)  PE index of head event
- aer_ts  out  TS_WIDTH  timestep of head event
- step_ready  out  1  high when no timestep drain is in progress
- overflow  out  1  sticky: a spike edge was dropped
- step_err  out  1  sticky: step_end arrived while draining

## Operation
- Edge capture:
  - `spike_q` registers `spike_in`.
  - `edge = spike_in & ~spike_q`.
  - `pend[i]` is set by `edge[i]` and cleared by a grant to i.
- Simultaneous edge and grant on the same bit: `pend[i]` stays 1, so the new event is kept.
- Edge on a bit already pending and not granted that cycle: the edge is dropped and `overflow` is set.
- Arbiter:
  - Grants at most one event per cycle.
  - Grants only when `pend` is non-zero and the FIFO is not full.
  - Full is evaluated before any same-cycle pop, so no grant occurs when full even if a pop happens that cycle.
  - Winner is the lowest index ≥ `ptr`, wrapping to 0.
  - On a grant: `ptr` ← winner+1, wrapping from NUM_PE−1 to 0.
  - Grant writes `{winner, ts}` into the FIFO.
- FIFO:
  - Push on grant; pop on `aer_valid & aer_ready`.
  - Simultaneous push and pop is legal when not full.
  - Count width is $clog2(FIFO_DEPTH)+1.
  - `aer_addr` and `aer_ts` show the head entry and are 0 while empty.
- Timestep FSM, states IDLE and DRAIN:
  - IDLE with `step_end` and `pend` == 0: `ts` ← `ts`+1, stay in IDLE.
  - IDLE with `step_end` and `pend` ≠ 0: go to DRAIN.
  - DRAIN: new edges are still captured and are stamped with the current `ts`.
  - DRAIN with `pend` == 0 after this cycle's updates: `ts` ← `ts`+1, go to IDLE.
  - `step_end` in DRAIN: ignored, `step_err` set.
  - `step_ready` = (state == IDLE).
- `ts` wraps from 2^TS_WIDTH−1 to 0.
- `overflow` and `step_err` clear only on reset.
- Reset mid-operation: all state returns immediately to reset values. Pending events and FIFO contents are discarded.

## Timing
- Reset values:
  - Internal: `spike_q`=0, `pend`=0, `ptr`=0, `ts`=0, FIFO empty, FSM in IDLE.
  - Outputs: `aer_valid`=0, `aer_addr`=0, `aer_ts`=0, `step_ready`=1, `overflow`=0, `step_err`=0.
- Latency, when the FIFO is not full and no other events are pending:
  - `spike_in` rises and is sampled at edge k.
  - `pend` is set after edge k.
  - The grant pushes the event at edge k+1.
  - `aer_valid`=1 during the cycle after edge k+1.
- Throughput: one event per cycle in and out.
- Pop: head advances at the edge where `aer_valid & aer_ready`.
- Drain: `step_ready` falls at the edge after `step_end` is sampled and rises at the edge where the last pending bit is granted. `ts` increments at that same edge.

## Test plan
- Single spike: NUM_PE=8, `aer_ready`=1, `spike_in[3]` rises at edge 5 → `aer_valid`=1 after edge 6 with `aer_addr`=3, `aer_ts`=0, for exactly one cycle even though `spike_in[3]` stays high.
- Round-robin: `spike_in` 0→8'hFF in one cycle, `aer_ready`=1 → addresses 0..7 on eight consecutive cycles. Then with `ptr`=0, bits 2 and 5 rise → order 2, 5.
- Backpressure/full: FIFO_DEPTH=4, `aer_ready`=0, all eight PEs spike → `aer_valid` held with addresses 0..3 queued and `pend`=8'hF0. Then `aer_ready`=1 → 0..7 delivered in order, no overflow.
- Overflow: `aer_ready`=0, FIFO full, PE 1 pending; drop `spike_in[1]` and raise it again → `overflow`=1; only one event from PE 1 is eventually delivered.
- Timestep/drain: events pending, pulse `step_end` → `step_ready`=0 until the last grant. Those events carry `aer_ts`=0. `ts`=1 afterwards. A second `step_end` during the drain sets `step_err`=1.
- Wrap and reset: TS_WIDTH=2, four `step_end` pulses with no spikes → `ts` returns to 0. Assert `reset_n`=0 with FIFO non-empty → `aer_valid`=0 and `step_ready`=1 immediately, without waiting for a clock edge.
